mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Byte-wide memory arbiter that shares the single 8-bit RAM port between the instruction-fetch requester and the load/store data requester. It serialises each 1/2/4-byte request into consecutive byte accesses, assembles little-endian read words with sign/zero extension, and returns a one-cycle ready pulse per transaction. It sits between the fetch queue / load-store buffer and the RAM, and is the only block that drives `ram_addr`, `ram_we` and `ram_wdata`.

## Interface
- Parameters: none; size encodings and width constants come from `mem_arb_pkg`.
- Reset: one clock; reset is synchronous and active-low (`rst` low at a rising edge of `clk` resets the block).
- `clk  in  1`  system clock, all state updates on its rising edge.
- `rst  in  1`  synchronous reset, active-low.
- `if_req  in  1`  fetch request; held high with `if_addr` stable until `if_ready`.
- `if_addr  in  32`  fetch byte address; fetches are always 4 bytes.
- `if_ready  out  1`  one-cycle pulse; `if_data` valid in that cycle.
- `if_data  out  32`  fetched word; holds its value until the next fetch completes.
- `d_req  in  1`  data request; held high with all `d_*` inputs stable until `d_ready`.
- `d_we  in  1`  1 = store, 0 = load.
- `d_size  in  2`  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `d_signed  in  1`  load sign-extends when 1; ignored for stores and words.
- `d_addr  in  32`  data byte address; no alignment check.
- `d_wdata  in  32`  store data; low `n` bytes are used.
- `d_ready  out  1`  one-cycle pulse at completion of a load or store.
- `d_rdata  out  32`  extended load result; holds until the next load completes.
- `ram_addr  out  32`  RAM byte address.
- `ram_we  out  1`  RAM write strobe.
- `ram_wdata  out  8`  RAM write byte.
- `ram_rdata  in  8`  RAM read byte, valid one cycle after its address is driven.
- `busy  out  1`  high in every state except IDLE.

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: `src` (fetch/data), `cnt` (0..3), `n` (1, 2 or 4 bytes), `last_grant`, and a 32-bit assembly register.
- Arbitration in IDLE: a single request wins. When both are pending, the requester not equal to `last_grant` wins. `last_grant` resets to fetch, so the first simultaneous conflict goes to data. `last_grant` updates on every acceptance.
- Acceptance edge:
  - Latch `src`, `n`, address, wdata and signed.
  - Drive `ram_addr` = addr.
  - Store: enter WRITE; drive `ram_we`=1 and `ram_wdata`=byte 0.
  - Load or fetch: enter READ.
- READ: each edge captures `ram_rdata` into byte `cnt` of the assembly register and drives `ram_addr` = addr+`cnt`+1 while bytes remain. After byte `n-1` is captured:
  - pulse the owner's ready;
  - load the owner's data output: fetch raw; load extended from bit 7 or 15 per `d_signed`;
  - enter DONE.
- WRITE: each edge drives byte `cnt` at addr+`cnt` with `ram_we`=1. The edge after byte `n-1` drops `ram_we`, pulses `d_ready` and enters DONE.
- DONE: lasts one cycle and ignores all requests, so a requester that has just seen ready is not re-accepted. Then the block returns to IDLE.
- Address arithmetic is 32-bit modulo, so 0xFFFFFFFF+1 wraps to 0.
- In IDLE and DONE: `ram_we`=0 and `ram_addr`=0.
- Reset, including mid-transaction:
  - Next state IDLE; `ram_we`=0 immediately; no ready pulse.
  - Bytes already written stay in RAM.
  - All outputs go to 0; `last_grant` goes to fetch.

## Timing
- Acceptance edge E0. Ready is registered at edge E`n`, so it is high `n` cycles after acceptance: 4 for a fetch or word access, 2 for a half, 1 for a byte.
- A back-to-back transaction can be accepted no earlier than edge E`n+2`, giving throughput of one transaction per `n`+2 cycles.
- No preemption: a request arriving mid-transaction waits for IDLE.
- `if_ready` and `d_ready` are never high in the same cycle.

## Structure
- `mem_arb_pkg`: `d_size` encodings (SZ_B, SZ_H, SZ_W), state enum (IDLE/READ/WRITE/DONE), source enum (SRC_IF/SRC_D), byte-count function.
- Sub-module `load_extend`: combinational; inputs 32-bit raw word, size and signed; output 32-bit extended value. The top instantiates it on the data-load path only.

## Test plan
- Fetch word at 0x100, RAM bytes 13 05 00 00 -> `if_ready` high 4 cycles after acceptance, `if_data`=0x00000513; `ram_addr` steps 0x100..0x103 on consecutive cycles.
- LB at 0x40 holding 0x80 with `d_signed`=1 -> `d_rdata`=0xFFFFFF80 after 1 cycle; LHU at 0x42 holding 01 80 -> 0x00008001 after 2 cycles.
- SW 0xDEADBEEF at 0x20 -> `ram_we` high 4 consecutive cycles writing EF, BE, AD, DE at 0x20..0x23; `d_ready` pulses in the next cycle, with `ram_we`=0.
- `if_req` and `d_req` both high right after reset -> data served first, one DONE cycle, then fetch. Both raised again -> data wins.
- `if_req` held high across `if_ready` -> DONE gap of one cycle, then second acceptance; `busy` low for exactly one cycle between the transactions.
- Reset asserted after 2 bytes of an SW -> `ram_we`=0 from that edge, no `d_ready`, `busy`=0. A fetch issued next completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - size encodings, state/source enums and byte-count helper for mem_arbiter
package mem_arb_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_t;

  // Size code 3 is deliberately folded into the word case.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_B:    byte_count = 3'd1;
      SZ_H:    byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of an assembled little-endian load word
module load_extend
  import mem_arb_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] ext
);

  // Replicate bit 7 or 15 only for signed byte/half loads; words pass through.
  always_comb begin
    ext = raw;
    case (size)
      SZ_B:    ext = {{24{is_signed & raw[7]}}, raw[7:0]};
      SZ_H:    ext = {{16{is_signed & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM port arbiter between instruction fetch and load/store
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        busy
);

  state_t      state_q, state_d;
  src_t        src_q, src_d;
  src_t        last_grant_q, last_grant_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;

  logic        grant_d_side;
  logic        last_byte;
  logic [1:0]  cnt_inc;
  logic [31:0] asm_next;
  logic [31:0] load_ext;

  // Data wins when it is alone, or when both are pending and fetch had the previous grant.
  assign grant_d_side = d_req & (~if_req | (last_grant_q == SRC_IF));
  assign last_byte    = ({1'b0, cnt_q} == (n_q - 3'd1));
  assign cnt_inc      = cnt_q + 2'd1;

  // Merge the byte arriving this cycle into the assembly word at position cnt.
  always_comb begin
    asm_next = asm_q;
    asm_next[{cnt_q, 3'b000} +: 8] = ram_rdata;
  end

  load_extend u_load_extend (
    .raw       (asm_next),
    .size      (size_q),
    .is_signed (sign_q),
    .ext       (load_ext)
  );

  // Next-state and registered-output logic; RAM strobes and ready pulses default low.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    size_d       = size_q;
    sign_d       = sign_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    if_data_d    = if_data_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    ram_addr_d   = 32'd0;
    ram_we_d     = 1'b0;
    ram_wdata_d  = 8'd0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          src_d        = grant_d_side ? SRC_D : SRC_IF;
          last_grant_d = grant_d_side ? SRC_D : SRC_IF;
          addr_d       = grant_d_side ? d_addr : if_addr;
          size_d       = grant_d_side ? d_size : SZ_W;
          n_d          = byte_count(grant_d_side ? d_size : SZ_W);
          sign_d       = grant_d_side & d_signed;
          wdata_d      = d_wdata;
          cnt_d        = 2'd0;
          asm_d        = 32'd0;
          ram_addr_d   = grant_d_side ? d_addr : if_addr;
          if (grant_d_side && d_we) begin
            state_d     = WRITE;
            ram_we_d    = 1'b1;
            ram_wdata_d = d_wdata[7:0];
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        asm_d = asm_next;
        if (last_byte) begin
          state_d = DONE;
          if (src_q == SRC_IF) begin
            if_ready_d = 1'b1;
            if_data_d  = asm_next;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = load_ext;
          end
        end else begin
          cnt_d      = cnt_inc;
          ram_addr_d = addr_q + {30'd0, cnt_inc};
        end
      end
      WRITE: begin
        if (last_byte) begin
          state_d   = DONE;
          d_ready_d = 1'b1;
        end else begin
          cnt_d       = cnt_inc;
          ram_addr_d  = addr_q + {30'd0, cnt_inc};
          ram_we_d    = 1'b1;
          ram_wdata_d = wdata_q[{cnt_inc, 3'b000} +: 8];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      src_q        <= SRC_IF;
      last_grant_q <= SRC_IF;
      cnt_q        <= 2'd0;
      n_q          <= 3'd0;
      size_q       <= 2'd0;
      sign_q       <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      asm_q        <= 32'd0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      if_data_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
      ram_addr_q   <= 32'd0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      if_data_q    <= if_data_d;
      d_rdata_q    <= d_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign if_data   = if_data_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        busy;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_data   (if_data),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_size    (d_size),
    .d_signed  (d_signed),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1 KiB RAM aliased on the low 10 address bits; combinational read, write on the edge.
  logic [7:0] mem [0:1023];
  logic       poke_en;
  logic [9:0] poke_addr;
  logic [7:0] poke_data;
  assign ram_rdata = mem[ram_addr[9:0]];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  logic [7:0] ref_mem [0:1023];
  int errs, checks;
  bit both_ready;
  logic [31:0] log_addr [0:7];
  logic        log_we   [0:7];
  logic [7:0]  log_wd   [0:7];
  int nlog;

  typedef struct {
    int          kind;   // 0 fetch, 1 load, 2 store
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    bit          pre;
    logic [31:0] pv;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t tv [0:16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    poke_en = 1'b1;
    poke_addr = a[9:0];
    poke_data = b;
    ref_mem[a[9:0]] = b;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] p;
    logic [31:0] s;
    for (int i = 0; i < 4; i++) begin
      p = a + 32'(i);
      s = w >> (8 * i);
      poke(p, s[7:0]);
    end
  endtask

  function automatic int nbytes(input int kind, input logic [1:0] sz);
    if (kind == 0) return 4;
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Little-endian gather from the shadow memory, then two's-complement fold by subtraction.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit sg);
    longint v;
    logic [31:0] p;
    v = 0;
    for (int i = 0; i < n; i++) begin
      p = a + 32'(i);
      v = v + (longint'(ref_mem[p[9:0]]) << (8 * i));
    end
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    logic [31:0] p;
    logic [31:0] s;
    for (int i = 0; i < n; i++) begin
      p = a + 32'(i);
      s = wd >> (8 * i);
      ref_mem[p[9:0]] = s[7:0];
    end
  endtask

  // Issue one request from an idle DUT; returns data and edges-to-ready (0 on timeout).
  task automatic run_txn(input int kind, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] data, output int lat);
    bit mine;
    if (kind == 0) begin
      if_req = 1'b1;
      if_addr = a;
    end else begin
      d_req = 1'b1;
      d_we = (kind == 2);
      d_size = sz;
      d_signed = sg;
      d_addr = a;
      d_wdata = wd;
    end
    lat = 0;
    data = 32'd0;
    nlog = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (nlog < 8) begin
        log_addr[nlog] = ram_addr;
        log_we[nlog] = ram_we;
        log_wd[nlog] = ram_wdata;
        nlog++;
      end
      if (if_ready && d_ready) both_ready = 1'b1;
      mine = (kind == 0) ? if_ready : d_ready;
      if ((kind == 0) ? d_ready : if_ready) both_ready = 1'b1;
      if (mine) begin
        lat = k + 1;
        data = (kind == 0) ? if_data : d_rdata;
        break;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] data;
    logic [31:0] s;
    logic [31:0] exp_a;
    int lat, n, kind, t1, t2, t_d, t_if, low, mism;
    logic [1:0] sz;
    logic sg, ok;
    logic [31:0] a, wd;

    errs = 0;
    checks = 0;
    both_ready = 1'b0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_signed = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0;
    poke_en = 1'b0; poke_addr = 10'd0; poke_data = 8'd0;

    // Fill the whole RAM while reset is held.
    for (int i = 0; i < 1024; i++) poke(32'(i), 8'($urandom_range(0, 255)));

    check("reset_flags", {28'd0, if_ready, d_ready, ram_we, busy}, 32'd0);
    check("reset_if_data", if_data, 32'd0);
    check("reset_d_rdata", d_rdata, 32'd0);
    check("reset_ram_addr", ram_addr, 32'd0);
    check("reset_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    tv[0]  = '{0, 2'd2, 1'b0, 32'h00000100, 32'h0, 1'b1, 32'h00000513, 32'h00000513, 5};
    tv[1]  = '{1, 2'd0, 1'b1, 32'h00000040, 32'h0, 1'b1, 32'h00000080, 32'hFFFFFF80, 2};
    tv[2]  = '{1, 2'd1, 1'b0, 32'h00000042, 32'h0, 1'b1, 32'h00008001, 32'h00008001, 3};
    tv[3]  = '{1, 2'd1, 1'b1, 32'h00000042, 32'h0, 1'b0, 32'h0,        32'hFFFF8001, 3};
    tv[4]  = '{1, 2'd0, 1'b0, 32'h00000040, 32'h0, 1'b0, 32'h0,        32'h00000080, 2};
    tv[5]  = '{1, 2'd0, 1'b1, 32'h00000044, 32'h0, 1'b1, 32'h0000007F, 32'h0000007F, 2};
    tv[6]  = '{1, 2'd2, 1'b1, 32'h00000048, 32'h0, 1'b1, 32'h80000001, 32'h80000001, 5};
    tv[7]  = '{1, 2'd3, 1'b0, 32'h00000048, 32'h0, 1'b0, 32'h0,        32'h80000001, 5};
    tv[8]  = '{2, 2'd2, 1'b0, 32'h00000020, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0,        5};
    tv[9]  = '{1, 2'd2, 1'b0, 32'h00000020, 32'h0, 1'b0, 32'h0,        32'hDEADBEEF, 5};
    tv[10] = '{2, 2'd0, 1'b0, 32'h00000030, 32'h12345678, 1'b1, 32'hAAAAAAAA, 32'h0, 2};
    tv[11] = '{1, 2'd2, 1'b0, 32'h00000030, 32'h0, 1'b0, 32'h0,        32'hAAAAAA78, 5};
    tv[12] = '{2, 2'd1, 1'b0, 32'h00000031, 32'h0000CAFE, 1'b0, 32'h0, 32'h0,        3};
    tv[13] = '{1, 2'd2, 1'b0, 32'h00000030, 32'h0, 1'b0, 32'h0,        32'hAACAFE78, 5};
    tv[14] = '{1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b1, 32'h44332211, 32'h44332211, 5};
    tv[15] = '{0, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0D0C0B0A, 32'h0D0C0B0A, 5};
    tv[16] = '{1, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0000C0DE, 32'hFFFFC0DE, 3};

    for (int v = 0; v < 17; v++) begin
      if (tv[v].pre) poke_word(tv[v].a, tv[v].pv);
      run_txn(tv[v].kind, tv[v].sz, tv[v].sg, tv[v].a, tv[v].wd, data, lat);
      n = nbytes(tv[v].kind, tv[v].sz);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(tv[v].lat));
      if (tv[v].kind != 2) check($sformatf("vec%0d_data", v), data, tv[v].exp);
      else ref_store(tv[v].a, n, tv[v].wd);
      // RAM port must step addr..addr+n-1 on consecutive cycles, then release the strobe.
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
        exp_a = tv[v].a + 32'(i);
        s = tv[v].wd >> (8 * i);
        if (log_addr[i] !== exp_a) ok = 1'b0;
        if (log_we[i] !== (tv[v].kind == 2)) ok = 1'b0;
        if (tv[v].kind == 2 && log_wd[i] !== s[7:0]) ok = 1'b0;
      end
      if (log_we[n] !== 1'b0) ok = 1'b0;
      check($sformatf("vec%0d_ram_seq", v), {31'd0, ok}, 32'd1);
    end

    // Randomised traffic against the shadow-memory model.
    for (int r = 0; r < 80; r++) begin
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a = $urandom;
      wd = $urandom;
      n = nbytes(kind, sz);
      run_txn(kind, sz, sg, a, wd, data, lat);
      check($sformatf("rand%0d_latency", r), 32'(lat), 32'(n + 1));
      if (kind == 2) ref_store(a, n, wd);
      else check($sformatf("rand%0d_data", r), data, ref_load(a, n, (kind == 1) && sg));
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("ram_image", 32'(mism), 32'd0);

    // Simultaneous requests straight after reset: data first, then fetch.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h00000200;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_signed = 1'b0; d_addr = 32'h00000300;
    t_d = 0; t_if = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (if_ready && d_ready) both_ready = 1'b1;
      if (d_ready && t_d == 0) begin
        t_d = k;
        check("conflict1_d_rdata", d_rdata, ref_load(32'h300, 4, 1'b0));
        d_req = 1'b0;
      end
      if (if_ready && t_if == 0) begin
        t_if = k;
        check("conflict1_if_data", if_data, ref_load(32'h200, 4, 1'b0));
        if_req = 1'b0;
      end
      if (t_if != 0) break;
    end
    check("conflict1_data_time", 32'(t_d), 32'd5);
    check("conflict1_fetch_time", 32'(t_if), 32'd11);
    @(posedge clk); #1;

    // Second simultaneous pair: fetch held the last grant, so data wins again.
    if_req = 1'b1; d_req = 1'b1;
    t_d = 0; t_if = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (if_ready) t_if = k;
      if (d_ready) t_d = k;
      if (if_ready || d_ready) break;
    end
    if_req = 1'b0; d_req = 1'b0;
    check("conflict2_data_time", 32'(t_d), 32'd5);
    check("conflict2_no_fetch", 32'(t_if), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Fetch held across its ready: one DONE cycle, one idle cycle, then re-acceptance.
    if_req = 1'b1; if_addr = 32'h00000104;
    t1 = 0; t2 = 0; low = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (if_ready && d_ready) both_ready = 1'b1;
      if (t1 != 0 && !if_ready && !busy) low++;
      if (if_ready) begin
        if (t1 == 0) t1 = k;
        else begin
          t2 = k;
          break;
        end
      end
    end
    if_req = 1'b0;
    check("held_fetch_gap", 32'(t2 - t1), 32'd6);
    check("held_fetch_busy_low", 32'(low), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Reset after two bytes of a word store.
    poke_word(32'h60, 32'hFFFFFFFF);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h60; d_wdata = 32'h11223344;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_flags", {29'd0, ram_we, busy, d_ready}, 32'd0);
    rst = 1'b1;
    d_req = 1'b0; d_we = 1'b0;
    t_d = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (d_ready || busy) t_d++;
    end
    check("rst_mid_quiet", 32'(t_d), 32'd0);
    check("rst_mid_ram", {mem[10'h63], mem[10'h62], mem[10'h61], mem[10'h60]}, 32'hFFFF3344);
    run_txn(0, 2'd2, 1'b0, 32'h60, 32'h0, data, lat);
    check("post_rst_fetch_data", data, 32'hFFFF3344);
    check("post_rst_fetch_latency", 32'(lat), 32'd5);

    check("ready_overlap", {31'd0, both_ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
